// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-to-1 registered round-robin stream multiplexer.
package mux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic MODE_RR     = 1'b0;
    localparam logic MODE_FORCED = 1'b1;

    // Width of a channel index; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo CHANNELS.
module rr_pick
    import mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = idx_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [CHANNELS-1:0] gnt,
    output logic [SEL_W-1:0]    idx,
    output logic                any
);

    int               cand;
    logic [SEL_W-1:0] cand_idx;

    always_comb begin
        gnt      = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand     = (int'(ptr) + k) % CHANNELS;
            cand_idx = SEL_W'(cand);
            if (!any && req[cand_idx]) begin
                gnt[cand_idx] = 1'b1;
                idx           = cand_idx;
                any           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-to-1 registered stream multiplexer with round-robin or forced channel selection.
// State table:  EMPTY | output register empty, out_valid=0
//               FULL  | output register holds a word, out_valid=1
module mux_nto1_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 64,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = idx_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
);

    state_t               state, state_nxt;
    logic [SEL_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [WIDTH-1:0]     ch_data [CHANNELS];

    logic [CHANNELS-1:0]  rr_gnt;
    logic [SEL_W-1:0]     rr_idx;
    logic                 rr_any;

    logic [CHANNELS-1:0]  fc_gnt;
    logic                 fc_any;

    logic [CHANNELS-1:0]  grant;
    logic [SEL_W-1:0]     grant_idx;
    logic                 grant_any;
    logic                 can_load;
    logic                 load;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .CHANNELS (CHANNELS)
    ) u_rr_pick (
        .req (in_valid),
        .ptr (rr_ptr),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    // Forced select grants nothing for an out-of-range sel.
    always_comb begin
        fc_gnt = '0;
        fc_any = 1'b0;
        if (int'(sel) < CHANNELS) begin
            if (in_valid[sel]) begin
                fc_gnt[sel] = 1'b1;
                fc_any      = 1'b1;
            end
        end
    end

    always_comb begin
        if (mode == MODE_FORCED) begin
            grant     = fc_gnt;
            grant_idx = sel;
            grant_any = fc_any;
        end else begin
            grant     = rr_gnt;
            grant_idx = rr_idx;
            grant_any = rr_any;
        end
    end

    assign out_valid = (state == FULL);
    assign can_load  = (state == EMPTY) | (out_ready & out_valid);
    // No channel is offered a transfer while reset is asserted.
    assign in_ready  = (can_load & ~rst) ? grant : '0;
    assign load      = can_load & grant_any & ~rst;

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        case (state)
            EMPTY: begin
                if (load) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (load) begin
                    state_nxt = FULL;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (load && (mode == MODE_RR)) begin
            rr_ptr_nxt = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0
                                                            : grant_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_chan <= '0;
        end else if (load) begin
            out_data <= ch_data[grant_idx];
            out_chan <= grant_idx;
        end
    end

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Scoreboard bench for mux_nto1_rr with a transaction-level reference model.
module tb_mux_nto1_rr;

    localparam int WIDTH    = 64;
    localparam int CHANNELS = 4;

    logic                      clk;
    logic                      rst;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [1:0]                sel;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [1:0]                out_chan;
    logic                      out_ready;

    typedef struct {
        int               chan;
        logic [WIDTH-1:0] data;
    } word_t;

    word_t sb[$];
    int    seen[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // reference model state: is a word held, and where the rotation resumes
    bit    m_full = 1'b0;
    int    m_ptr  = 0;

    mux_nto1_rr #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected grant from the rules: rotate from m_ptr in RR, else the selected channel.
    function automatic int pick(input logic [3:0] v, input logic md, input logic [1:0] s, input int p);
        if (md == 1'b0) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (v[(p + k) % CHANNELS]) return (p + k) % CHANNELS;
            end
            return -1;
        end
        if (int'(s) < CHANNELS && v[s]) return int'(s);
        return -1;
    endfunction

    // Reference model: evaluated mid-cycle, predicts the handshake at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            begin
                int         g;
                bit         can;
                logic [3:0] exp_rdy;
                word_t      w;
                g       = pick(in_valid, mode, sel, m_ptr);
                can     = !m_full || out_ready;
                exp_rdy = (!rst && can && g >= 0) ? (4'b0001 << g) : 4'b0000;
                check("in_ready", 64'(in_ready), 64'(exp_rdy));
                check("out_valid", 64'(out_valid), 64'(m_full));
                if (rst) begin
                    m_full = 1'b0;
                    m_ptr  = 0;
                    sb.delete();
                end else if (exp_rdy != 4'b0000) begin
                    w.chan = g;
                    w.data = in_data[g*WIDTH +: WIDTH];
                    sb.push_back(w);
                    m_full = 1'b1;
                    if (mode == 1'b0) m_ptr = (g + 1) % CHANNELS;
                end else if (m_full && out_ready) begin
                    m_full = 1'b0;
                end
            end
        end
    end

    // Monitor: every accepted output word must be the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid === 1'b1 && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got word ch%0d %h, expected none", out_chan, out_data);
                end else begin
                    word_t e;
                    e = sb.pop_front();
                    check("out_chan", 64'(out_chan), 64'(e.chan));
                    check("out_data", out_data, e.data);
                end
                seen.push_back(int'(out_chan));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic seq_data();
        for (int i = 0; i < CHANNELS; i++) in_data[i*WIDTH +: WIDTH] = 64'hA0 + 64'(i);
    endtask

    task automatic rand_data();
        for (int i = 0; i < CHANNELS; i++) in_data[i*WIDTH +: WIDTH] = {$urandom, $urandom};
    endtask

    task automatic expect_seen(input string name, input int base, input int n, input int exp_list[]);
        if (seen.size() < base + n) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got %0d words expected %0d", name, seen.size() - base, n);
        end else begin
            for (int i = 0; i < n; i++) check(name, 64'(seen[base + i]), 64'(exp_list[i]));
        end
    endtask

    initial begin
        int base;
        rst       = 1'b1;
        in_valid  = 4'hF;
        mode      = 1'b0;
        sel       = 2'd0;
        out_ready = 1'b1;
        seq_data();

        // reset held two cycles with every channel valid
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_chan", 64'(out_chan), 64'd0);
        rst = 1'b0;

        // round-robin fairness, one word per cycle
        repeat (6) cycle();
        expect_seen("rr_order", 0, 5, '{0, 1, 2, 3, 0});

        // backpressure then release
        out_ready = 1'b0;
        repeat (4) cycle();
        out_ready = 1'b1;
        repeat (3) cycle();

        // forced select, then an unavailable forced channel
        mode = 1'b1;
        sel  = 2'd2;
        repeat (5) cycle();
        sel      = 2'd3;
        in_valid = 4'b0111;
        repeat (3) cycle();
        check("forced_drain", 64'(out_valid), 64'd0);
        mode     = 1'b0;
        in_valid = 4'hF;
        repeat (2) cycle();
        in_valid = 4'h0;
        repeat (2) cycle();

        // sparse requests and pointer wrap
        base     = seen.size();
        in_valid = 4'b0100;
        cycle();
        in_valid = 4'b0010;
        cycle();
        in_valid = 4'b1111;
        cycle();
        in_valid = 4'h0;
        repeat (2) cycle();
        expect_seen("sparse_wrap", base, 3, '{2, 1, 2});

        // reset while a word is held under backpressure
        in_valid  = 4'hF;
        out_ready = 1'b0;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        base      = seen.size();
        repeat (2) cycle();
        in_valid = 4'h0;
        repeat (2) cycle();
        expect_seen("midrst_resume", base, 2, '{0, 1});

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 63) == 0);
            mode      = ($urandom_range(0, 3) == 0);
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            cycle();
        end

        rst       = 1'b0;
        in_valid  = 4'h0;
        out_ready = 1'b1;
        repeat (3) cycle();
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("final_out_valid", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
